cvbs_pattern_gen: RTL and testbench
===================================

// Module: cvbs_pattern_gen
// PURPOSE
//  Synthesizable composite-video stimulus generator. Produces a W-bit CVBS sample
//  stream with selectable vertical-sync conventions (PAL normal, BK, Vector-06C long
//  pulse), an optional baseline-drift impairment, and ground-truth sync flags.
//  Drives syncdetect on hardware and in benches, replacing hand-timed stimulus.
// PARAMETERS
//  W          6     CVBS sample width
//  BLACK      12    blanking/black level above sync tip
//  WHITE_BASE 15    active-video base level (ramp added on top)
//  LINE_CLK   1536  clocks per line (64us @ 24MHz)
//  LINES      322   lines per field; line counter wraps LINES-1 -> 0
//  FPORCH     40    front porch clocks
//  HS_N       113   hsync width, NORMAL/BK modes (4.7us)
//  HS_V       257   hsync width, VECTOR mode (10.7us)
//  BPORCH     137   back porch clocks
//  SSYNC      48    short/equalising pulse width (2us)
//  LSYNC      720   long (broad) pulse width (30us)
//  EQP        528   BK equalising-pulse period (22us)
//  VLONG      672   VECTOR vertical pulse width per line (28us)
//  VBL_V      24    VECTOR vertical-interval lines
//  DRIFT_EN   1     enable baseline drift in VECTOR mode
//  DRIFT_UP   2     accumulator increment per clock, VECTOR lines 0..5
//  DRIFT_DN   6     accumulator decrement per clock, VECTOR lines >= VBL_V
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  ce           in   1   clock enable; all state advances only when ce=1
//  mode         in   2   0 NORMAL, 1 BK, 2 VECTOR, 3 reserved (= NORMAL)
//  cvbs         out  W   composite sample
//  hs_ref       out  1   1 while cvbs is at sync-tip level outside the vertical interval
//  vs_ref       out  1   1 for all clocks of vertical-interval lines
//  field_start  out  1   one-clock pulse at line 0, pixel 0
//  line         out  9   current line number
//  pixel        out  11  current pixel number
// BEHAVIOUR
//  Reset (async): pixel=0, line=0, glob=0, drift acc=0, cvbs=0, hs_ref=0, vs_ref=0,
//   field_start=0, active mode=NORMAL. Reset mid-line abandons the line immediately.
//  Counters (ce=1): pixel 0..LINE_CLK-1; at LINE_CLK-1 pixel->0, line increments,
//   wrapping LINES-1 -> 0. ce=0 freezes counters, acc and all outputs.
//  mode is sampled only at field_start; mid-field changes take effect next field.
//  Outputs registered: cvbs/hs_ref/vs_ref reflect (line,pixel) of previous clock.
//  floor = acc[15:12] (zero-extended to W); sync tip = floor; black = floor+BLACK.
//  Active line (pixel p): p<FPORCH black; <FPORCH+HS sync tip (HS = HS_V in VECTOR,
//   else HS_N); <FPORCH+HS+BPORCH black; else floor+WHITE_BASE+p[3:0].
//  NORMAL vertical interval = lines 0..5; active from line 6:
//   lines 0-1: tip for p<LSYNC and LINE_CLK/2<=p<LINE_CLK/2+LSYNC, else black;
//   line 2: first half-line as lines 0-1, second pulse width SSYNC;
//   lines 3-5: tip for p<SSYNC and LINE_CLK/2<=p<LINE_CLK/2+SSYNC.
//  BK vertical interval = lines 0..2: glob counts clocks from line 0 pixel 0;
//   black when (glob mod EQP)<SSYNC, else tip. glob cleared on line 3.
//  VECTOR vertical interval = lines 0..VBL_V-1: tip for p<VLONG, else black;
//   ramp suppressed on lines VBL_V and VBL_V+1.
//  Drift (VECTOR and DRIFT_EN only): lines 0..5 acc+=DRIFT_UP saturating at 16'hFFFF;
//   lines >= VBL_V acc-=DRIFT_DN saturating at 0; other lines hold. Other modes: acc=0.
//  Arithmetic: every level sum computed at W+2 bits, saturated to 2^W-1.
//  hs_ref=1 only on active lines during hsync; vs_ref=1 on vertical-interval lines.
// TESTING
//  1 NORMAL, reset then ce=1: line 10, pixel 40..152 -> cvbs=0, hs_ref=1; pixel 153 ->
//    cvbs=12; pixel 400 -> cvbs=15+(400&15)=15; field_start every 322*1536 clocks.
//  2 NORMAL line 0: cvbs=0 for pixels 0..719 and 768..1487, 12 elsewhere; vs_ref=1;
//    line 2 second pulse ends at pixel 815.
//  3 BK lines 0..2: cvbs=12 for glob mod 528 in 0..47, else 0; line 3 normal hsync.
//  4 VECTOR DRIFT_EN=1: after line 5 acc=2*6*1536=18432 (floor=4), sync tip=4, black=16;
//    line 24 acc drains 6/clk to 0 by pixel 3072 of drift; hsync width 257 clocks.
//  5 mode 0->2 written at line 100: output stays NORMAL until next field_start, then
//    VECTOR pulses of 672 clocks on lines 0..23.
//  6 ce toggled 1/0 every clock: all timings double in clk cycles; reset asserted at
//    line 50 -> cvbs=0, line=0 asynchronously; resumes from line 0 pixel 0.

Source files
------------

// File: rtl/cvbs_pattern_gen_if.sv
// Bundle between the CVBS stimulus generator and its consumer (sync detector or bench).
// Each clock with ce=1 is a valid beat: the generator advances one sample, and there is no backpressure.
interface cvbs_pattern_gen_if #(
  parameter int W = 6
);
  logic         ce;
  logic [1:0]   mode;
  logic [W-1:0] cvbs;
  logic         hs_ref;
  logic         vs_ref;
  logic         field_start;
  logic [8:0]   line;
  logic [10:0]  pixel;

  modport master (
    input  ce, mode,
    output cvbs, hs_ref, vs_ref, field_start, line, pixel
  );

  modport slave (
    output ce, mode,
    input  cvbs, hs_ref, vs_ref, field_start, line, pixel
  );
endinterface

// File: rtl/cvbs_pattern_gen.sv
// Composite-video stimulus generator: NORMAL / BK / VECTOR vertical sync styles,
// optional baseline drift in VECTOR mode, and registered ground-truth sync flags.
module cvbs_pattern_gen #(
  parameter int W          = 6,
  parameter int BLACK      = 12,
  parameter int WHITE_BASE = 15,
  parameter int LINE_CLK   = 1536,
  parameter int LINES      = 322,
  parameter int FPORCH     = 40,
  parameter int HS_N       = 113,
  parameter int HS_V       = 257,
  parameter int BPORCH     = 137,
  parameter int SSYNC      = 48,
  parameter int LSYNC      = 720,
  parameter int EQP        = 528,
  parameter int VLONG      = 672,
  parameter int VBL_V      = 24,
  parameter bit DRIFT_EN   = 1'b1,
  parameter int DRIFT_UP   = 2,
  parameter int DRIFT_DN   = 6
) (
  input logic                clk,
  input logic                reset,
  cvbs_pattern_gen_if.master bus
);
  localparam int LW = W + 2;
  localparam int GW = $clog2(EQP + 1);
  localparam logic [1:0] M_NORMAL = 2'd0;
  localparam logic [1:0] M_BK     = 2'd1;
  localparam logic [1:0] M_VECTOR = 2'd2;
  localparam logic [LW-1:0] LVL_MAX = LW'((1 << W) - 1);

  logic [10:0]   pixel_q;
  logic [8:0]    line_q;
  logic [15:0]   acc_q;
  logic [GW-1:0] glob_q;
  logic [1:0]    mode_q;
  logic [W-1:0]  cvbs_q;
  logic          hs_q;
  logic          vs_q;
  logic          fs_q;

  logic          first_px;
  logic [1:0]    eff_mode;
  logic [10:0]   pixel_n;
  logic [8:0]    line_n;
  logic [15:0]   acc_n;
  logic [GW-1:0] glob_n;

  logic [LW-1:0] floor_l;
  logic [LW-1:0] black_l;
  logic [LW-1:0] ramp;
  logic [LW-1:0] level;
  logic [10:0]   hs_w;
  logic [10:0]   hs_end;
  logic [10:0]   bp_end;
  logic [10:0]   half;
  logic [10:0]   w1;
  logic [10:0]   w2;
  logic          vert;
  logic          in_tip;
  logic          hsync;

  function automatic logic [W-1:0] sat_lvl(input logic [LW-1:0] v);
    return (v > LVL_MAX) ? LVL_MAX[W-1:0] : v[W-1:0];
  endfunction

  // The mode for the whole field is taken at line 0 pixel 0, including that first sample.
  always_comb begin
    first_px = (line_q == 9'd0) && (pixel_q == 11'd0);
    eff_mode = first_px ? bus.mode : mode_q;
    if (eff_mode == 2'd3) eff_mode = M_NORMAL;
  end

  always_comb begin
    pixel_n = pixel_q + 11'd1;
    line_n  = line_q;
    if (pixel_q == 11'(LINE_CLK - 1)) begin
      pixel_n = '0;
      line_n  = (line_q == 9'(LINES - 1)) ? '0 : line_q + 9'd1;
    end

    // glob is kept modulo EQP directly; it only matters inside the BK vertical interval.
    glob_n = '0;
    if (line_q <= 9'd2) glob_n = (glob_q == GW'(EQP - 1)) ? '0 : glob_q + GW'(1);

    acc_n = acc_q;
    if (eff_mode != M_VECTOR || !DRIFT_EN)
      acc_n = '0;
    else if (line_q <= 9'd5)
      acc_n = (acc_q > 16'(16'hFFFF - DRIFT_UP)) ? 16'hFFFF : acc_q + 16'(DRIFT_UP);
    else if (line_q >= 9'(VBL_V))
      acc_n = (acc_q < 16'(DRIFT_DN)) ? '0 : acc_q - 16'(DRIFT_DN);
  end

  always_comb begin
    floor_l = LW'(acc_q[15:12]);
    black_l = floor_l + LW'(BLACK);
    hs_w    = (eff_mode == M_VECTOR) ? 11'(HS_V) : 11'(HS_N);
    hs_end  = 11'(FPORCH) + hs_w;
    bp_end  = hs_end + 11'(BPORCH);
    half    = 11'(LINE_CLK / 2);
    w1      = (line_q <= 9'd2) ? 11'(LSYNC) : 11'(SSYNC);
    w2      = (line_q <= 9'd1) ? 11'(LSYNC) : 11'(SSYNC);
    ramp    = LW'(pixel_q[3:0]);
    in_tip  = 1'b0;
    hsync   = 1'b0;
    level   = black_l;

    case (eff_mode)
      M_BK:     vert = (line_q <= 9'd2);
      M_VECTOR: vert = (line_q < 9'(VBL_V));
      default:  vert = (line_q <= 9'd5);
    endcase

    if (vert) begin
      case (eff_mode)
        M_BK:     in_tip = (glob_q >= GW'(SSYNC));
        M_VECTOR: in_tip = (pixel_q < 11'(VLONG));
        default:  in_tip = (pixel_q < w1) || (pixel_q >= half && pixel_q < half + w2);
      endcase
      level = in_tip ? floor_l : black_l;
    end else begin
      hsync = (pixel_q >= 11'(FPORCH)) && (pixel_q < hs_end);
      if (eff_mode == M_VECTOR && (line_q == 9'(VBL_V) || line_q == 9'(VBL_V + 1)))
        ramp = '0;
      if (pixel_q < 11'(FPORCH))  level = black_l;
      else if (hsync)             level = floor_l;
      else if (pixel_q < bp_end)  level = black_l;
      else                        level = floor_l + LW'(WHITE_BASE) + ramp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_q <= '0;
      line_q  <= '0;
      acc_q   <= '0;
      glob_q  <= '0;
      mode_q  <= M_NORMAL;
      cvbs_q  <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (bus.ce) begin
      pixel_q <= pixel_n;
      line_q  <= line_n;
      acc_q   <= acc_n;
      glob_q  <= glob_n;
      if (first_px) mode_q <= eff_mode;
      cvbs_q  <= sat_lvl(level);
      hs_q    <= hsync;
      vs_q    <= vert;
      fs_q    <= first_px;
    end
  end

  assign bus.cvbs        = cvbs_q;
  assign bus.hs_ref      = hs_q;
  assign bus.vs_ref      = vs_q;
  assign bus.field_start = fs_q;
  assign bus.line        = line_q;
  assign bus.pixel       = pixel_q;
endmodule

// File: tb/tb_cvbs_pattern_gen.sv
// Bench for cvbs_pattern_gen. Timings are scaled down (192-clock lines, 30-line fields)
// so several fields of every mode, drift saturation and a mid-line reset fit in a short run.
module tb_cvbs_pattern_gen;
  localparam int W          = 6;
  localparam int BLACK      = 12;
  localparam int WHITE_BASE = 40;
  localparam int LINE_CLK   = 192;
  localparam int LINES      = 30;
  localparam int FPORCH     = 5;
  localparam int HS_N       = 14;
  localparam int HS_V       = 32;
  localparam int BPORCH     = 17;
  localparam int SSYNC      = 6;
  localparam int LSYNC      = 90;
  localparam int EQP        = 66;
  localparam int VLONG      = 84;
  localparam int VBL_V      = 24;
  localparam int DRIFT_UP   = 64;
  localparam int DRIFT_DN   = 96;
  localparam int EW         = W + 3 + 9 + 11;
  localparam int FIELD      = LINES * LINE_CLK;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cvbs_pattern_gen_if #(.W(W)) bus ();

  cvbs_pattern_gen #(
    .W(W), .BLACK(BLACK), .WHITE_BASE(WHITE_BASE), .LINE_CLK(LINE_CLK), .LINES(LINES),
    .FPORCH(FPORCH), .HS_N(HS_N), .HS_V(HS_V), .BPORCH(BPORCH), .SSYNC(SSYNC),
    .LSYNC(LSYNC), .EQP(EQP), .VLONG(VLONG), .VBL_V(VBL_V), .DRIFT_EN(1'b1),
    .DRIFT_UP(DRIFT_UP), .DRIFT_DN(DRIFT_DN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state: position within field, drift accumulator, field mode
  int m_pos;
  int m_acc;
  int m_mode;
  int fld;
  int plan [6] = '{0, 2, 2, 1, 3, 0};

  function automatic int sat(input int v);
    return (v > (1 << W) - 1) ? (1 << W) - 1 : v;
  endfunction

  function automatic logic [EW-1:0] expect_at(input int l, input int p, input int md,
                                              input int acc, input int npos);
    int fl, blk, hs_w, lvl, w1, w2;
    bit vert, tipz, hs;
    fl   = acc / 4096;
    blk  = fl + BLACK;
    hs_w = (md == 2) ? HS_V : HS_N;
    vert = (md == 1) ? (l < 3) : (md == 2) ? (l < VBL_V) : (l < 6);
    hs   = 1'b0;
    if (vert) begin
      if (md == 1)
        tipz = ((l * LINE_CLK + p) % EQP) >= SSYNC;
      else if (md == 2)
        tipz = p < VLONG;
      else begin
        w1 = (l < 3) ? LSYNC : SSYNC;
        w2 = (l < 2) ? LSYNC : SSYNC;
        tipz = (p < w1) || (p >= LINE_CLK / 2 && p < LINE_CLK / 2 + w2);
      end
      lvl = tipz ? fl : blk;
    end else begin
      hs = (p >= FPORCH) && (p < FPORCH + hs_w);
      if (p < FPORCH)                      lvl = blk;
      else if (hs)                         lvl = fl;
      else if (p < FPORCH + hs_w + BPORCH) lvl = blk;
      else lvl = fl + WHITE_BASE + ((md == 2 && (l == VBL_V || l == VBL_V + 1)) ? 0 : p % 16);
    end
    return {W'(sat(lvl)), hs, vert, (l == 0 && p == 0), 9'(npos / LINE_CLK), 11'(npos % LINE_CLK)};
  endfunction

  // driver: one clock of stimulus, pushing the expected sample when ce is asserted
  task automatic step(input bit ce);
    int l, p, np;
    bus.ce = ce;
    if (ce) begin
      l = m_pos / LINE_CLK;
      p = m_pos % LINE_CLK;
      if (m_pos == 0) m_mode = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
      np = (m_pos + 1) % FIELD;
      exp_q.push_back(expect_at(l, p, m_mode, m_acc, np));
      if (m_mode != 2)        m_acc = 0;
      else if (l < 6)         m_acc = (m_acc + DRIFT_UP > 65535) ? 65535 : m_acc + DRIFT_UP;
      else if (l >= VBL_V)    m_acc = (m_acc - DRIFT_DN < 0) ? 0 : m_acc - DRIFT_DN;
      m_pos = np;
      if (np == 0) fld++;
      // a stray write early in the field, then the real choice for the next field
      if (np == 4 * LINE_CLK + 33) bus.mode = 2'($urandom_range(0, 3));
      if (np == (LINES / 2) * LINE_CLK) bus.mode = 2'(plan[fld + 1]);
    end
  endtask

  task automatic check_zero(input string name);
    logic [EW-1:0] act;
    act = {bus.cvbs, bus.hs_ref, bus.vs_ref, bus.field_start, bus.line, bus.pixel};
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL %s: got %h, want all-zero outputs", name, act);
    end
  endtask

  // monitor: compares every beat the DUT advanced on
  initial begin
    logic c;
    logic [EW-1:0] act, exp_v;
    forever begin
      @(posedge clk);
      c = bus.ce && !reset;
      #1;
      if (c) begin
        vectors++;
        act = {bus.cvbs, bus.hs_ref, bus.vs_ref, bus.field_start, bus.line, bus.pixel};
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sample: got %h with no expected entry", act);
        end else begin
          exp_v = exp_q.pop_front();
          if (act !== exp_v) begin
            miscompares++;
            $display("FAIL sample @%0t: got cvbs=%0d hs=%0b vs=%0b fs=%0b line=%0d pixel=%0d, want cvbs=%0d hs=%0b vs=%0b fs=%0b line=%0d pixel=%0d",
                     $time, act[EW-1 -: W], act[22], act[21], act[20], act[19:11], act[10:0],
                     exp_v[EW-1 -: W], exp_v[22], exp_v[21], exp_v[20], exp_v[19:11], exp_v[10:0]);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    bit tog;
    bit rst_done;
    reset    = 1'b1;
    bus.ce   = 1'b0;
    bus.mode = 2'(plan[0]);
    m_pos    = 0;
    m_acc    = 0;
    m_mode   = 0;
    fld      = 0;
    cyc      = 0;
    tog      = 1'b0;
    rst_done = 1'b0;
    #12;
    check_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;

    while (fld < 5 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (!rst_done && fld == 3 && m_pos == 20 * LINE_CLK + 77) begin
        bus.ce   = 1'b0;
        rst_done = 1'b1;
        #3 reset = 1'b1;
        #1 check_zero("reset_mid_line");
        @(negedge clk);
        reset  = 1'b0;
        m_pos  = 0;
        m_acc  = 0;
        m_mode = 0;
      end else if (fld == 1) begin
        tog = !tog;
        step(tog);
      end else begin
        step($urandom_range(0, 3) != 0);
      end
    end

    if (fld < 5) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: reached field %0d of 5 after %0d cycles", fld, cyc);
    end

    @(negedge clk);
    bus.ce = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected samples never produced, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
